cmp_arbiter: RTL and testbench

Shared-comparator arbiter for the execute stage. Grants a single `brcomp` instance to two requesters: the branch unit (BEQ/BNE/BLT/BGE/BLTU/BGEU) and the ALU set-less-than path (SLT/SLTU/SLTI/SLTIU). It latches the winning operands, evaluates them, and returns a registered result over per-requester valid/ready handshakes. It supports pipeline flush of in-flight branch work.

---
 rtl/cmp_pkg.sv | 29 ++
 rtl/brcomp.sv | 21 ++
 rtl/cmp_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cmp_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and funct3 encodings for the execute-stage comparator arbiter.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } cmp_state_e;

    typedef enum logic {
        OWN_BR  = 1'b0,
        OWN_SLT = 1'b1
    } cmp_owner_e;

    localparam int unsigned F3_W = 3;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    // 010 and 011 have no branch meaning
    function automatic logic f3_illegal(input logic [F3_W-1:0] f3);
        return f3[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/brcomp.sv
// Equality and less-than comparator with selectable signedness.
module brcomp #(
    parameter int unsigned n = 32
) (
    input  logic         clk_i,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         br_signed,
    output logic         br_eq,
    output logic         br_less
);

    always_comb begin
        br_eq   = (a == b);
        br_less = br_signed ? ($signed(a) < $signed(b)) : (a < b);
    end

    // Signedness must always be a resolved level when the result is captured
    assert property (@(posedge clk_i) !$isunknown(br_signed));

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator between the branch unit and the SLT path.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         br_req_valid_i,
    output logic         br_req_ready_o,
    input  logic [n-1:0] br_rs1_i,
    input  logic [n-1:0] br_rs2_i,
    input  logic [2:0]   br_funct3_i,
    output logic         br_rsp_valid_o,
    input  logic         br_rsp_ready_i,
    output logic         br_taken_o,
    output logic         br_illegal_o,
    input  logic         slt_req_valid_i,
    output logic         slt_req_ready_o,
    input  logic [n-1:0] slt_a_i,
    input  logic [n-1:0] slt_b_i,
    input  logic         slt_signed_i,
    output logic         slt_rsp_valid_o,
    input  logic         slt_rsp_ready_i,
    output logic         slt_less_o,
    output logic         busy_o
);

    cmp_state_e      state;
    cmp_owner_e      owner;
    logic            last_slt;
    logic [n-1:0]    op_a;
    logic [n-1:0]    op_b;
    logic            signed_q;
    logic [F3_W-1:0] funct3_q;

    logic br_cand;
    logic br_acc;
    logic slt_acc;
    logic cmp_eq;
    logic cmp_less;
    logic taken_c;

    // A flush masks the branch request before arbitration
    assign br_cand = br_req_valid_i && !flush_i;

    always_comb begin
        br_req_ready_o  = 1'b0;
        slt_req_ready_o = 1'b0;
        if (rst_ni && state == IDLE) begin
            if (br_cand && slt_req_valid_i) begin
                br_req_ready_o  = last_slt;
                slt_req_ready_o = !last_slt;
            end else begin
                br_req_ready_o  = br_cand;
                slt_req_ready_o = slt_req_valid_i;
            end
        end
    end

    assign br_acc  = br_req_valid_i && br_req_ready_o;
    assign slt_acc = slt_req_valid_i && slt_req_ready_o;

    brcomp #(.n(n)) u_brcomp (
        .clk_i     (clk_i),
        .a         (op_a),
        .b         (op_b),
        .br_signed (signed_q),
        .br_eq     (cmp_eq),
        .br_less   (cmp_less)
    );

    always_comb begin
        taken_c = 1'b0;
        case (funct3_q)
            F3_BEQ:  taken_c = cmp_eq;
            F3_BNE:  taken_c = !cmp_eq;
            F3_BLT:  taken_c = cmp_less;
            F3_BGE:  taken_c = !cmp_less;
            F3_BLTU: taken_c = cmp_less;
            F3_BGEU: taken_c = !cmp_less;
            default: taken_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state           <= IDLE;
            owner           <= OWN_BR;
            last_slt        <= 1'b1;
            op_a            <= '0;
            op_b            <= '0;
            signed_q        <= 1'b0;
            funct3_q        <= F3_BEQ;
            br_rsp_valid_o  <= 1'b0;
            br_taken_o      <= 1'b0;
            br_illegal_o    <= 1'b0;
            slt_rsp_valid_o <= 1'b0;
            slt_less_o      <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (br_acc) begin
                        state    <= EVAL;
                        owner    <= OWN_BR;
                        last_slt <= 1'b0;
                        op_a     <= br_rs1_i;
                        op_b     <= br_rs2_i;
                        signed_q <= !br_funct3_i[1];
                        funct3_q <= br_funct3_i;
                        busy_o   <= 1'b1;
                    end else if (slt_acc) begin
                        state    <= EVAL;
                        owner    <= OWN_SLT;
                        last_slt <= 1'b1;
                        op_a     <= slt_a_i;
                        op_b     <= slt_b_i;
                        signed_q <= slt_signed_i;
                        busy_o   <= 1'b1;
                    end
                end
                EVAL: begin
                    if (owner == OWN_BR && flush_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        state <= RESP;
                        if (owner == OWN_BR) begin
                            br_rsp_valid_o <= 1'b1;
                            br_taken_o     <= taken_c;
                            br_illegal_o   <= f3_illegal(funct3_q);
                        end else begin
                            slt_rsp_valid_o <= 1'b1;
                            slt_less_o      <= cmp_less;
                        end
                    end
                end
                RESP: begin
                    // Flush wins over a same-cycle branch handshake
                    if (owner == OWN_BR) begin
                        if (flush_i || br_rsp_ready_i) begin
                            state          <= IDLE;
                            busy_o         <= 1'b0;
                            br_rsp_valid_o <= 1'b0;
                            br_taken_o     <= 1'b0;
                            br_illegal_o   <= 1'b0;
                        end
                    end else if (slt_rsp_ready_i) begin
                        state           <= IDLE;
                        busy_o          <= 1'b0;
                        slt_rsp_valid_o <= 1'b0;
                        slt_less_o      <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios then randomized traffic vs a transaction model.
module tb_cmp_arbiter;

    localparam int unsigned N = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic         br_req_valid_i;
    logic         br_req_ready_o;
    logic [N-1:0] br_rs1_i;
    logic [N-1:0] br_rs2_i;
    logic [2:0]   br_funct3_i;
    logic         br_rsp_valid_o;
    logic         br_rsp_ready_i;
    logic         br_taken_o;
    logic         br_illegal_o;
    logic         slt_req_valid_i;
    logic         slt_req_ready_o;
    logic [N-1:0] slt_a_i;
    logic [N-1:0] slt_b_i;
    logic         slt_signed_i;
    logic         slt_rsp_valid_o;
    logic         slt_rsp_ready_i;
    logic         slt_less_o;
    logic         busy_o;

    always #5 clk_i = ~clk_i;

    cmp_arbiter #(.n(N)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .br_req_valid_i  (br_req_valid_i),
        .br_req_ready_o  (br_req_ready_o),
        .br_rs1_i        (br_rs1_i),
        .br_rs2_i        (br_rs2_i),
        .br_funct3_i     (br_funct3_i),
        .br_rsp_valid_o  (br_rsp_valid_o),
        .br_rsp_ready_i  (br_rsp_ready_i),
        .br_taken_o      (br_taken_o),
        .br_illegal_o    (br_illegal_o),
        .slt_req_valid_i (slt_req_valid_i),
        .slt_req_ready_o (slt_req_ready_o),
        .slt_a_i         (slt_a_i),
        .slt_b_i         (slt_b_i),
        .slt_signed_i    (slt_signed_i),
        .slt_rsp_valid_o (slt_rsp_valid_o),
        .slt_rsp_ready_i (slt_rsp_ready_i),
        .slt_less_o      (slt_less_o),
        .busy_o          (busy_o)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Transaction-level model: one job in flight, age 1 = evaluating, age 2 = responding
    bit m_pend    = 1'b0;
    int m_age     = 0;
    bit m_own_slt = 1'b0;
    bit m_ptr_slt = 1'b1;
    bit m_taken   = 1'b0;
    bit m_illegal = 1'b0;
    bit m_less    = 1'b0;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, got, exp);
    endtask

    // {illegal, taken} straight from the RISC-V branch definitions
    function automatic logic [1:0] br_model(input logic [2:0] f3, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        case (f3)
            3'b000:  return {1'b0, a == b};
            3'b001:  return {1'b0, a != b};
            3'b100:  return {1'b0, $signed(a) <  $signed(b)};
            3'b101:  return {1'b0, $signed(a) >= $signed(b)};
            3'b110:  return {1'b0, a <  b};
            3'b111:  return {1'b0, a >= b};
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [N-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return N'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF - N'($urandom_range(0, 3));
            default: return N'($urandom);
        endcase
    endfunction

    // Inputs are already driven; check this cycle's outputs, then advance the model over the edge
    task automatic cycle();
        bit exp_br_rdy;
        bit exp_slt_rdy;
        bit bw;
        bit show;
        logic [1:0] br_res;
        @(negedge clk_i);
        exp_br_rdy  = 1'b0;
        exp_slt_rdy = 1'b0;
        bw = br_req_valid_i && !flush_i;
        if (rst_ni && !m_pend) begin
            if (bw && slt_req_valid_i) begin
                exp_br_rdy  = m_ptr_slt;
                exp_slt_rdy = !m_ptr_slt;
            end else begin
                exp_br_rdy  = bw;
                exp_slt_rdy = slt_req_valid_i;
            end
        end
        show = m_pend && (m_age == 2);
        check("br_req_ready",  br_req_ready_o,  exp_br_rdy);
        check("slt_req_ready", slt_req_ready_o, exp_slt_rdy);
        check("br_rsp_valid",  br_rsp_valid_o,  show && !m_own_slt);
        check("br_taken",      br_taken_o,      show && !m_own_slt && m_taken);
        check("br_illegal",    br_illegal_o,    show && !m_own_slt && m_illegal);
        check("slt_rsp_valid", slt_rsp_valid_o, show && m_own_slt);
        check("slt_less",      slt_less_o,      show && m_own_slt && m_less);
        check("busy",          busy_o,          m_pend);

        if (!rst_ni) begin
            m_pend    = 1'b0;
            m_ptr_slt = 1'b1;
        end else if (m_pend) begin
            if (!m_own_slt && flush_i) m_pend = 1'b0;
            else if (m_age == 2) begin
                if (m_own_slt ? slt_rsp_ready_i : br_rsp_ready_i) m_pend = 1'b0;
            end else m_age = 2;
        end else if (exp_br_rdy && br_req_valid_i) begin
            br_res    = br_model(br_funct3_i, br_rs1_i, br_rs2_i);
            m_pend    = 1'b1;
            m_age     = 1;
            m_own_slt = 1'b0;
            m_ptr_slt = 1'b0;
            m_taken   = br_res[0];
            m_illegal = br_res[1];
        end else if (exp_slt_rdy && slt_req_valid_i) begin
            m_pend    = 1'b1;
            m_age     = 1;
            m_own_slt = 1'b1;
            m_ptr_slt = 1'b1;
            m_less    = slt_signed_i ? ($signed(slt_a_i) < $signed(slt_b_i)) : (slt_a_i < slt_b_i);
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic quiet();
        rst_ni          = 1'b1;
        flush_i         = 1'b0;
        br_req_valid_i  = 1'b0;
        slt_req_valid_i = 1'b0;
        br_rsp_ready_i  = 1'b1;
        slt_rsp_ready_i = 1'b1;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic br_req(input logic [2:0] f3, input logic [N-1:0] a, input logic [N-1:0] b);
        br_req_valid_i = 1'b1;
        br_funct3_i    = f3;
        br_rs1_i       = a;
        br_rs2_i       = b;
        cycle();
        br_req_valid_i = 1'b0;
        br_rs1_i       = ~a;
        run(3);
    endtask

    task automatic slt_req(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
        slt_req_valid_i = 1'b1;
        slt_signed_i    = sgn;
        slt_a_i         = a;
        slt_b_i         = b;
        cycle();
        slt_req_valid_i = 1'b0;
        slt_a_i         = ~a;
        run(3);
    endtask

    initial begin
        quiet();
        rst_ni       = 1'b0;
        br_rs1_i     = '0;
        br_rs2_i     = '0;
        br_funct3_i  = 3'b000;
        slt_a_i      = '0;
        slt_b_i      = '0;
        slt_signed_i = 1'b0;
        @(posedge clk_i);
        #1;
        cycle();
        rst_ni = 1'b1;

        // Equality and signedness on fixed operands
        br_req(3'b000, 32'h0000_1234, 32'h0000_1234);
        br_req(3'b001, 32'h0000_1234, 32'h0000_1234);
        br_req(3'b100, 32'hFFFF_FFFF, 32'h0000_0001);
        br_req(3'b110, 32'hFFFF_FFFF, 32'h0000_0001);
        slt_req(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        slt_req(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
        br_req(3'b010, 32'h0000_0005, 32'h0000_0005);

        // Contention from reset: tie goes to the branch unit first, then alternates
        rst_ni = 1'b0;
        cycle();
        rst_ni          = 1'b1;
        br_req_valid_i  = 1'b1;
        slt_req_valid_i = 1'b1;
        br_funct3_i     = 3'b101;
        br_rs1_i        = 32'h8000_0000;
        br_rs2_i        = 32'h0000_0001;
        slt_signed_i    = 1'b0;
        slt_a_i         = 32'h8000_0000;
        slt_b_i         = 32'h0000_0001;
        run(12);
        quiet();
        run(3);

        // SLT response stalled with the branch unit waiting
        slt_req_valid_i = 1'b1;
        slt_signed_i    = 1'b1;
        slt_a_i         = 32'h0000_0003;
        slt_b_i         = 32'h0000_0007;
        cycle();
        slt_req_valid_i = 1'b0;
        slt_rsp_ready_i = 1'b0;
        br_req_valid_i  = 1'b1;
        br_funct3_i     = 3'b111;
        run(5);
        slt_rsp_ready_i = 1'b1;
        run(2);
        br_req_valid_i = 1'b0;
        run(3);

        // Flush in branch EVAL, then flush during an SLT job
        br_req_valid_i = 1'b1;
        br_funct3_i    = 3'b000;
        cycle();
        br_req_valid_i = 1'b0;
        flush_i        = 1'b1;
        cycle();
        flush_i = 1'b0;
        run(2);
        slt_req_valid_i = 1'b1;
        slt_signed_i    = 1'b0;
        slt_a_i         = 32'h0000_0001;
        slt_b_i         = 32'h0000_0002;
        cycle();
        slt_req_valid_i = 1'b0;
        flush_i         = 1'b1;
        run(2);
        flush_i = 1'b0;
        run(2);

        // Reset while the branch response is stalled
        br_req_valid_i = 1'b1;
        br_funct3_i    = 3'b100;
        br_rsp_ready_i = 1'b0;
        cycle();
        br_req_valid_i = 1'b0;
        run(2);
        rst_ni = 1'b0;
        cycle();
        rst_ni          = 1'b1;
        br_rsp_ready_i  = 1'b1;
        br_req_valid_i  = 1'b1;
        slt_req_valid_i = 1'b1;
        cycle();
        quiet();
        run(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_ni          = ($urandom_range(0, 99) != 0);
            flush_i         = ($urandom_range(0, 7) == 0);
            br_req_valid_i  = 1'($urandom_range(0, 1));
            slt_req_valid_i = 1'($urandom_range(0, 1));
            br_rsp_ready_i  = ($urandom_range(0, 9) < 7);
            slt_rsp_ready_i = ($urandom_range(0, 9) < 7);
            br_funct3_i     = 3'($urandom_range(0, 7));
            br_rs1_i        = rand_op();
            br_rs2_i        = ($urandom_range(0, 3) == 0) ? br_rs1_i : rand_op();
            slt_a_i         = rand_op();
            slt_b_i         = ($urandom_range(0, 3) == 0) ? slt_a_i : rand_op();
            slt_signed_i    = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
